conv3_window_engine: RTL and testbench

- Downstream consumer of the address counter in the 1-D convolution path.
- Counts incoming samples written to the register file, then drives ReadEn so the three read addresses sweep the frame.
- Applies a 3-tap signed MAC with bias and ReLU to each window, through a 2-stage pipeline.
- Emits one result per window, then a frame-done pulse.

---
 rtl/conv3_window_engine_pkg.sv | 23 ++
 rtl/conv3_window_engine_mac.sv | 67 ++++++
 rtl/conv3_window_engine.sv | 152 +++++++++++++++
 tb/tb_conv3_window_engine.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/conv3_window_engine_pkg.sv
// Shared definitions for the 1-D convolution window engine.
//   state_t     : FSM state encoding (IDLE/FILL/CONV/DRAIN)
//   out_width   : result width for a given sample width
//   num_windows : windows per frame for a given frame length
package conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_CONV  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // Three full-width products plus bias fit with two guard bits.
  function automatic int unsigned out_width(input int unsigned dw);
    return 2 * dw + 2;
  endfunction

  function automatic int unsigned num_windows(input int unsigned dn);
    return dn - 2;
  endfunction

endpackage

// File: rtl/conv3_window_engine_mac.sv
// 2-stage signed 3-tap multiply, bias add and ReLU.
// Ports:
//   clk, rst_n           : clock, async active-low reset
//   in_valid             : window present on in_d0..2 this cycle
//   in_d0..2, in_w0..2   : signed samples and kernel weights
//   in_bias              : signed bias, sign-extended before the add
//   out_data, out_valid  : clamped result two cycles after in_valid
module conv3_mac
  import conv_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned OUTWIDTH  = 18
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic signed [DATAWIDTH-1:0] in_d0,
  input  logic signed [DATAWIDTH-1:0] in_d1,
  input  logic signed [DATAWIDTH-1:0] in_d2,
  input  logic signed [DATAWIDTH-1:0] in_w0,
  input  logic signed [DATAWIDTH-1:0] in_w1,
  input  logic signed [DATAWIDTH-1:0] in_w2,
  input  logic signed [DATAWIDTH-1:0] in_bias,
  output logic        [OUTWIDTH-1:0]  out_data,
  output logic                        out_valid
);

  localparam int unsigned PW = 2 * DATAWIDTH;

  logic signed [PW-1:0]       r_p0, r_p1, r_p2;
  logic                       r_v1;
  logic signed [OUTWIDTH-1:0] w_sum;

  // Stage 1: register the three products.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p0 <= '0;
      r_p1 <= '0;
      r_p2 <= '0;
      r_v1 <= 1'b0;
    end else begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_p0 <= in_d0 * in_w0;
        r_p1 <= in_d1 * in_w1;
        r_p2 <= in_d2 * in_w2;
      end
    end
  end

  // Signed size casts sign-extend before the add.
  assign w_sum = OUTWIDTH'(r_p0) + OUTWIDTH'(r_p1) + OUTWIDTH'(r_p2) + OUTWIDTH'(in_bias);

  // Stage 2: ReLU and register; data holds between valid results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= r_v1;
      if (r_v1) begin
        out_data <= w_sum[OUTWIDTH-1] ? '0 : w_sum;
      end
    end
  end

endmodule

// File: rtl/conv3_window_engine.sv
// Frame controller for the 3-tap convolution: counts written samples,
// sweeps the read addresses with ReadEn, and feeds the MAC pipeline.
// Ports:
//   clk, rst_n                : clock, async active-low reset
//   Start                     : sample-write strobe from the upstream writer
//   ReadData1..3              : current window from the register file
//   W0..W2, Bias              : kernel and bias, latched at end of FILL
//   ReadEn                    : advance read addresses (high in CONV)
//   DataOut, OutValid         : ReLU result and its valid
//   Busy                      : frame in progress
//   Done                      : pulse with the last result of the frame
module conv3_window_engine
  import conv_pkg::*;
#(
  parameter int unsigned ADDRESS   = 4,
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned DATANUM   = 15,
  localparam int unsigned OUTWIDTH = out_width(DATAWIDTH)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        Start,
  input  logic signed [DATAWIDTH-1:0] ReadData1,
  input  logic signed [DATAWIDTH-1:0] ReadData2,
  input  logic signed [DATAWIDTH-1:0] ReadData3,
  input  logic signed [DATAWIDTH-1:0] W0,
  input  logic signed [DATAWIDTH-1:0] W1,
  input  logic signed [DATAWIDTH-1:0] W2,
  input  logic signed [DATAWIDTH-1:0] Bias,
  output logic                        ReadEn,
  output logic        [OUTWIDTH-1:0]  DataOut,
  output logic                        OutValid,
  output logic                        Busy,
  output logic                        Done
);

  localparam int unsigned NWIN = num_windows(DATANUM);

  state_t                       r_state, w_next;
  logic [ADDRESS-1:0]           r_fill_cnt, w_fill_nxt;
  logic [ADDRESS-1:0]           r_win_cnt, w_win_nxt;
  logic                         r_drain, w_drain_nxt;
  logic                         w_latch;
  logic signed [DATAWIDTH-1:0]  r_w0, r_w1, r_w2, r_bias;
  logic                         r_last1, r_done;

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_fill_cnt <= '0;
      r_win_cnt  <= '0;
      r_drain    <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_fill_cnt <= w_fill_nxt;
      r_win_cnt  <= w_win_nxt;
      r_drain    <= w_drain_nxt;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    w_next      = r_state;
    w_fill_nxt  = r_fill_cnt;
    w_win_nxt   = r_win_cnt;
    w_drain_nxt = r_drain;
    w_latch     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (Start) begin
          w_next     = ST_FILL;
          w_fill_nxt = ADDRESS'(1);
        end
      end
      ST_FILL: begin
        if (Start) begin
          if (r_fill_cnt == ADDRESS'(DATANUM - 1)) begin
            w_next    = ST_CONV;
            w_win_nxt = '0;
            w_latch   = 1'b1;
          end else begin
            w_fill_nxt = r_fill_cnt + ADDRESS'(1);
          end
        end
      end
      ST_CONV: begin
        w_win_nxt = r_win_cnt + ADDRESS'(1);
        if (r_win_cnt == ADDRESS'(NWIN - 1)) begin
          w_next      = ST_DRAIN;
          w_drain_nxt = 1'b0;
        end
      end
      ST_DRAIN: begin
        w_drain_nxt = 1'b1;
        if (r_drain) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Kernel snapshot taken on the edge that completes the fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_w0   <= '0;
      r_w1   <= '0;
      r_w2   <= '0;
      r_bias <= '0;
    end else if (w_latch) begin
      r_w0   <= W0;
      r_w1   <= W1;
      r_w2   <= W2;
      r_bias <= Bias;
    end
  end

  // Last-window marker travels alongside the MAC pipeline to time Done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last1 <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_last1 <= (r_state == ST_CONV) && (r_win_cnt == ADDRESS'(NWIN - 1));
      r_done  <= r_last1;
    end
  end

  assign ReadEn = (r_state == ST_CONV);
  assign Busy   = (r_state != ST_IDLE);
  assign Done   = r_done;

  conv3_mac #(
    .DATAWIDTH(DATAWIDTH),
    .OUTWIDTH (OUTWIDTH)
  ) u_mac (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (ReadEn),
    .in_d0    (ReadData1),
    .in_d1    (ReadData2),
    .in_d2    (ReadData3),
    .in_w0    (r_w0),
    .in_w1    (r_w1),
    .in_w2    (r_w2),
    .in_bias  (r_bias),
    .out_data (DataOut),
    .out_valid(OutValid)
  );

endmodule

// File: tb/tb_conv3_window_engine.sv
// Directed bench for conv3_window_engine with a small register-file model.
module tb_conv3_window_engine;

  localparam int unsigned DN = 15;
  localparam int unsigned NW = 13;
  localparam int unsigned DW = 8;
  localparam int unsigned OW = 18;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n, Start;
  logic signed [DW-1:0] W0, W1, W2, Bias;
  logic signed [DW-1:0] ReadData1, ReadData2, ReadData3;
  logic                 ReadEn, OutValid, Busy, Done;
  logic        [OW-1:0] DataOut;

  conv3_window_engine #(.ADDRESS(4), .DATAWIDTH(DW), .DATANUM(DN)) dut (
    .clk(clk), .rst_n(rst_n), .Start(Start),
    .ReadData1(ReadData1), .ReadData2(ReadData2), .ReadData3(ReadData3),
    .W0(W0), .W1(W1), .W2(W2), .Bias(Bias),
    .ReadEn(ReadEn), .DataOut(DataOut), .OutValid(OutValid),
    .Busy(Busy), .Done(Done)
  );

  // Register file and upstream read-address counter.
  logic signed [DW-1:0] mem [64];
  logic [5:0] rd_ptr, wr_ptr;
  assign ReadData1 = mem[rd_ptr];
  assign ReadData2 = mem[rd_ptr + 6'd1];
  assign ReadData3 = mem[rd_ptr + 6'd2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)              rd_ptr <= 6'd0;
    else if (Start && !Busy) rd_ptr <= 6'd0;
    else if (ReadEn)         rd_ptr <= rd_ptr + 6'd1;
  end

  // Observation capture.
  int cyc = 0, re_cnt = 0, first_re = -1, first_ov = -1, last_start = 0;
  int done_cnt = 0, done_bad = 0;
  logic [31:0] done_val = 32'd0;
  int q_out[$];

  always @(negedge clk) begin
    cyc++;
    if (ReadEn) begin
      re_cnt++;
      if (first_re < 0) first_re = cyc;
    end
    if (OutValid) begin
      q_out.push_back(int'(DataOut));
      if (first_ov < 0) first_ov = cyc;
    end
    if (Start) last_start = cyc;
    if (Done) begin
      done_cnt++;
      done_val = 32'(DataOut);
      if (!OutValid) done_bad++;
    end
  end

  int n_chk = 0, n_pass = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int s);
    mem[wr_ptr] = DW'(s);
    wr_ptr = wr_ptr + 6'd1;
    Start = 1'b1;
    step();
    Start = 1'b0;
  endtask

  task automatic clear_mon();
    re_cnt = 0; first_re = -1; first_ov = -1;
    done_cnt = 0; done_bad = 0;
    q_out.delete();
    wr_ptr = 6'd0;
  endtask

  task automatic run_frame(input string tag, input int smp[15], input int wv0, input int wv1,
                           input int wv2, input int bv, input int ex[13],
                           input bit gaps, input bit tamper);
    int ls;
    clear_mon();
    W0 = DW'(wv0); W1 = DW'(wv1); W2 = DW'(wv2); Bias = DW'(bv);
    for (int i = 0; i < 15; i++) begin
      if (gaps) repeat (i % 4) step();
      send(smp[i]);
    end
    ls = last_start;
    if (tamper) begin
      step();
      W0 = 8'sd5; W1 = 8'sd5; W2 = 8'sd5;
      Start = 1'b1;
      step();
      Start = 1'b0;
    end
    for (int i = 0; i < 60 && !Done; i++) step();
    check({tag, " done_seen"}, 32'(Done), 32'd1);
    step();
    check({tag, " busy_after_done"}, 32'(Busy), 32'd0);
    check({tag, " done_single"}, 32'(Done), 32'd0);
    check({tag, " readen_cycles"}, re_cnt, NW);
    check({tag, " readen_latency"}, first_re, ls + 1);
    check({tag, " outvalid_latency"}, first_ov, first_re + 2);
    check({tag, " out_count"}, q_out.size(), NW);
    for (int k = 0; k < 13; k++) begin
      if (k < q_out.size()) check($sformatf("%s out%0d", tag, k), q_out[k], ex[k]);
    end
    check({tag, " done_count"}, done_cnt, 1);
    check({tag, " done_with_valid"}, done_bad, 0);
    check({tag, " done_value"}, done_val, ex[12]);
  endtask

  int smp[15];
  int ex[13];

  initial begin
    rst_n = 1'b0; Start = 1'b0;
    W0 = '0; W1 = '0; W2 = '0; Bias = '0;
    wr_ptr = 6'd0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    repeat (2) step();
    check("rst ReadEn", 32'(ReadEn), 32'd0);
    check("rst OutValid", 32'(OutValid), 32'd0);
    check("rst Busy", 32'(Busy), 32'd0);
    check("rst Done", 32'(Done), 32'd0);
    check("rst DataOut", 32'(DataOut), 32'd0);
    rst_n = 1'b1;
    step();

    // Basic frame: samples 1..15, unit kernel, outputs 6,9,...,42.
    for (int i = 0; i < 15; i++) smp[i] = i + 1;
    for (int k = 0; k < 13; k++) ex[k] = 3 * k + 6;
    run_frame("basic", smp, 1, 1, 1, 0, ex, 1'b0, 1'b0);

    // ReLU clamps every negative window to zero.
    for (int k = 0; k < 13; k++) ex[k] = 0;
    run_frame("relu_neg", smp, -1, 0, 0, 0, ex, 1'b0, 1'b0);

    // Third tap minus 3: k+3-3 = k.
    for (int k = 0; k < 13; k++) ex[k] = k;
    run_frame("relu_bias", smp, 0, 0, 1, -3, ex, 1'b0, 1'b0);

    // Extremes: 3*16384 + 127 = 49279.
    for (int i = 0; i < 15; i++) smp[i] = -128;
    for (int k = 0; k < 13; k++) ex[k] = 49279;
    run_frame("extreme", smp, -128, -128, -128, 127, ex, 1'b0, 1'b0);

    // Gapped Starts, weights changed and stray Start mid-CONV.
    for (int i = 0; i < 15; i++) smp[i] = i + 1;
    for (int k = 0; k < 13; k++) ex[k] = 3 * k + 6;
    run_frame("gapped", smp, 1, 1, 1, 0, ex, 1'b1, 1'b1);

    // Reset after the 5th result aborts the frame without Done.
    clear_mon();
    W0 = 8'sd1; W1 = 8'sd1; W2 = 8'sd1; Bias = 8'sd0;
    for (int i = 0; i < 15; i++) send(i + 1);
    for (int i = 0; i < 40 && q_out.size() < 5; i++) step();
    check("abort reached_5_outputs", 32'(q_out.size() >= 5), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort ReadEn", 32'(ReadEn), 32'd0);
    check("abort OutValid", 32'(OutValid), 32'd0);
    check("abort Busy", 32'(Busy), 32'd0);
    check("abort Done", 32'(Done), 32'd0);
    repeat (2) step();
    check("abort no_done", done_cnt, 0);
    rst_n = 1'b1;
    step();
    run_frame("after_reset", smp, 1, 1, 1, 0, ex, 1'b0, 1'b0);

    // Back-to-back: each frame begins right after the previous Busy fall.
    run_frame("b2b_a", smp, 1, 1, 1, 0, ex, 1'b0, 1'b0);
    run_frame("b2b_b", smp, 1, 1, 1, 0, ex, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
